// File: rtl/fsk_demodulate_pkg.sv
// Shared FSK link constants, demodulator state/class encodings and counter sizing.
// The tone constants are also the defaults used by the companion modulator.
package fsk_pkg;

    localparam int MARK_HALF  = 8;
    localparam int SPACE_HALF = 16;
    localparam int THRESH     = 12;
    localparam int MIN_HALF   = 4;
    localparam int MAX_HALF   = 24;
    localparam int CONFIRM    = 2;
    localparam int TIMEOUT    = 48;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_e;

    typedef enum logic [1:0] {
        CLS_INVALID,
        CLS_SPACE,
        CLS_MARK
    } cls_e;

    // Interval counter must be able to hold the saturation value TIMEOUT.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fsk_demodulate_if.sv
// Line side and recovered-data side of the FSK demodulator, bundled for port connection.
interface fsk_demodulate_if #(
    parameter int CNT_W = fsk_pkg::cnt_width(fsk_pkg::TIMEOUT)
);
    logic             fsk_in;
    logic             data_out;
    logic             data_valid;
    logic             carrier_lost;
    logic [CNT_W-1:0] interval;

    // master: the demodulator itself; slave: the line driver / link-level consumer.
    modport master (
        input  fsk_in,
        output data_out,
        output data_valid,
        output carrier_lost,
        output interval
    );

    modport slave (
        output fsk_in,
        input  data_out,
        input  data_valid,
        input  carrier_lost,
        input  interval
    );
endinterface

// File: rtl/fsk_demodulate_edge_timer.sv
// Synchronises the asynchronous FSK line, detects transitions and times the gap between them.
// The measured interval is presented combinationally alongside the edge strobe.
module fsk_edge_timer
    import fsk_pkg::*;
#(
    parameter int TIMEOUT = fsk_pkg::TIMEOUT,
    parameter int CNT_W   = cnt_width(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fsk_i,
    output logic             edge_o,
    output logic [CNT_W-1:0] interval_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic             sync1_q, sync2_q, sync3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign edge_o     = sync2_q != sync3_q;
    assign interval_o = cnt_q + CNT_W'(1);
    assign timeout_o  = (cnt_q == CNT_MAX) && !edge_o;

    // NOTE: every path assigns cnt_d a default first, so no latch can be inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_o) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignment so the sync chain shifts one stage per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= fsk_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/fsk_demodulate.sv
// FSK demodulator: classifies each transition interval as mark/space/invalid and
// debounces symbol changes through an IDLE/ACQUIRE/LOCKED state machine.
module fsk_demodulate
    import fsk_pkg::*;
#(
    parameter int MARK_HALF  = fsk_pkg::MARK_HALF,
    parameter int SPACE_HALF = fsk_pkg::SPACE_HALF,
    parameter int THRESH     = fsk_pkg::THRESH,
    parameter int MIN_HALF   = fsk_pkg::MIN_HALF,
    parameter int MAX_HALF   = fsk_pkg::MAX_HALF,
    parameter int CONFIRM    = fsk_pkg::CONFIRM,
    parameter int TIMEOUT    = fsk_pkg::TIMEOUT
) (
    input logic              clk,
    input logic              rst,
    fsk_demodulate_if.master bus
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam int RUN_W = $clog2(CONFIRM + 1);

    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HALF);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(CONFIRM);

    if (!(MIN_HALF < MARK_HALF && MARK_HALF <= THRESH && THRESH < SPACE_HALF &&
          SPACE_HALF <= MAX_HALF && MAX_HALF < TIMEOUT)) begin : g_bad_params
        $error("fsk_demodulate: illegal tone/threshold parameter ordering");
    end

    logic             edge_w, timeout_w;
    logic [CNT_W-1:0] meas_w;

    fsk_edge_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .fsk_i      (bus.fsk_in),
        .edge_o     (edge_w),
        .interval_o (meas_w),
        .timeout_o  (timeout_w)
    );

    state_e           state_q, state_d;
    logic             cand_q, cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             data_q, data_d;
    logic             valid_q, valid_d;
    logic             lost_q, lost_d;
    logic [CNT_W-1:0] interval_q, interval_d;

    cls_e             cls;
    logic             cls_bit;
    logic [RUN_W-1:0] run_inc;

    always_comb begin
        cls = CLS_INVALID;
        if (meas_w >= MIN_C && meas_w <= THRESH_C) begin
            cls = CLS_MARK;
        end else if (meas_w > THRESH_C && meas_w <= MAX_C) begin
            cls = CLS_SPACE;
        end
    end

    assign cls_bit = (cls == CLS_MARK);
    assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        run_d      = run_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        lost_d     = lost_q;
        interval_d = interval_q;

        // An edge always wins over a coincident timeout; its interval is then simply invalid.
        if (edge_w) begin
            interval_d = meas_w;
            case (state_q)
                IDLE: state_d = ACQUIRE;
                ACQUIRE: begin
                    if (cls == CLS_INVALID) begin
                        run_d = '0;
                    end else begin
                        if (cls_bit == cand_q) begin
                            run_d = run_inc;
                        end else begin
                            cand_d = cls_bit;
                            run_d  = RUN_W'(1);
                        end
                        if (run_d == RUN_MAX) begin
                            state_d = LOCKED;
                            data_d  = cand_d;
                            valid_d = 1'b1;
                            lost_d  = 1'b0;
                            run_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (cls == CLS_INVALID || cls_bit == data_q) begin
                        run_d = '0;
                    end else begin
                        cand_d = cls_bit;
                        run_d  = run_inc;
                        if (run_d == RUN_MAX) begin
                            data_d  = cls_bit;
                            valid_d = 1'b1;
                            run_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_w && state_q != IDLE) begin
            state_d = IDLE;
            lost_d  = 1'b1;
            data_d  = 1'b0;
            run_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cand_q     <= 1'b0;
            run_q      <= '0;
            data_q     <= 1'b0;
            valid_q    <= 1'b0;
            lost_q     <= 1'b1;
            interval_q <= '0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            run_q      <= run_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            lost_q     <= lost_d;
            interval_q <= interval_d;
        end
    end

    assign bus.data_out     = data_q;
    assign bus.data_valid   = valid_q;
    assign bus.carrier_lost = lost_q;
    assign bus.interval     = interval_q;

endmodule

// File: tb/tb_fsk_demodulate.sv
// Self-checking bench for fsk_demodulate: directed tone scenarios plus random intervals,
// compared every cycle against an interval-history model of the demodulation rules.
module tb_fsk_demodulate;
    import fsk_pkg::*;

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic clk = 1'b0;
    logic rst = 1'b1;

    fsk_demodulate_if #(.CNT_W(CNT_W)) bus ();

    fsk_demodulate dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Levels reach the decision logic two clocks after being sampled; the interval is the
    // number of clocks between successive processed transitions, capped at TIMEOUT+1.
    int  cyc = 0;
    int  last_evt = 0;
    bit  smp [3];
    bit  m_active, m_locked;
    bit  exp_data, exp_valid, exp_lost;
    int  exp_interval;
    int  hist [$];

    function automatic int classify(input int iv);
        if (iv >= MIN_HALF && iv <= THRESH) return 1;
        if (iv > THRESH && iv <= MAX_HALF) return 0;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        bit ev;
        bit all_same;
        int cntb;
        int c;
        if (rst) begin
            last_evt = cyc;
            smp = '{0, 0, 0};
            m_active = 0;
            m_locked = 0;
            exp_data = 0;
            exp_valid = 0;
            exp_lost = 1;
            exp_interval = 0;
            hist.delete();
        end else begin
            cyc++;
            ev = smp[1] != smp[2];
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = bus.fsk_in;
            cntb = cyc - last_evt - 1;
            if (cntb > TIMEOUT) cntb = TIMEOUT;
            exp_valid = 0;
            if (ev) begin
                exp_interval = cntb + 1;
                last_evt = cyc;
                if (!m_active) begin
                    m_active = 1;
                    hist.delete();
                end else begin
                    c = classify(cntb + 1);
                    hist.push_back(c);
                    // Accept when the most recent CONFIRM classifications are one valid new symbol.
                    if (c >= 0 && hist.size() >= CONFIRM && (!m_locked || c != int'(exp_data))) begin
                        all_same = 1;
                        for (int i = hist.size() - CONFIRM; i < hist.size(); i++)
                            if (hist[i] != c) all_same = 0;
                        if (all_same) begin
                            m_locked = 1;
                            exp_data = c[0];
                            exp_valid = 1;
                            exp_lost = 0;
                            hist.delete();
                        end
                    end
                end
            end else if (m_active && cntb == TIMEOUT) begin
                m_active = 0;
                m_locked = 0;
                exp_lost = 1;
                exp_data = 0;
                hist.delete();
            end
        end
        #1;
        check("data_out",     int'(bus.data_out),     int'(exp_data));
        check("data_valid",   int'(bus.data_valid),   int'(exp_valid));
        check("carrier_lost", int'(bus.carrier_lost), int'(exp_lost));
        check("interval",     int'(bus.interval),     exp_interval);
    end

    // ---------------- stimulus ----------------
    // Flip the line now (at a falling edge) and hold it for n clocks.
    task automatic toggle_wait(input int n);
        bus.fsk_in = ~bus.fsk_in;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int r;
        bus.fsk_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Mark tone: lock exactly two clocks after the third transition is sampled.
        toggle_wait(8);
        toggle_wait(8);
        bus.fsk_in = ~bus.fsk_in;
        @(posedge clk); #1 check("t1_dv_k", int'(bus.data_valid), 0);
        @(posedge clk); #1 check("t1_dv_k1", int'(bus.data_valid), 0);
        @(posedge clk); #1;
        check("t1_dv_k2", int'(bus.data_valid), 1);
        check("t1_data", int'(bus.data_out), 1);
        check("t1_lost", int'(bus.carrier_lost), 0);
        check("t1_interval", int'(bus.interval), 8);
        repeat (6) @(negedge clk);

        // Mark to space switch.
        repeat (3) toggle_wait(8);
        repeat (4) toggle_wait(16);
        check("t2_data", int'(bus.data_out), 0);
        check("t2_lost", int'(bus.carrier_lost), 0);

        // 2-clk glitch while locked on space.
        toggle_wait(2);
        toggle_wait(2);
        toggle_wait(12);
        repeat (3) toggle_wait(16);
        check("t3_data", int'(bus.data_out), 0);
        check("t3_lost", int'(bus.carrier_lost), 0);

        // Carrier loss, then relock on mark.
        repeat (70) @(negedge clk);
        check("t4_lost", int'(bus.carrier_lost), 1);
        check("t4_data", int'(bus.data_out), 0);
        repeat (5) toggle_wait(8);
        check("t4_relock_lost", int'(bus.carrier_lost), 0);
        check("t4_relock_data", int'(bus.data_out), 1);

        // Boundary intervals 12 (mark) and 13 (single space, not confirmed).
        toggle_wait(8);
        toggle_wait(12);
        repeat (2) toggle_wait(8);
        toggle_wait(13);
        repeat (3) toggle_wait(8);
        check("t5_data", int'(bus.data_out), 1);

        // Reset mid mark-to-space transition.
        toggle_wait(8);
        toggle_wait(8);
        toggle_wait(16);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        bus.fsk_in = 1'b0;
        #1;
        check("t6_rst_data", int'(bus.data_out), 0);
        check("t6_rst_dv", int'(bus.data_valid), 0);
        check("t6_rst_lost", int'(bus.carrier_lost), 1);
        check("t6_rst_interval", int'(bus.interval), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        repeat (2) toggle_wait(16);
        check("t6_not_yet", int'(bus.carrier_lost), 1);
        toggle_wait(16);
        check("t6_relock_lost", int'(bus.carrier_lost), 0);
        check("t6_relock_data", int'(bus.data_out), 0);

        // Random interval mix, including boundaries, glitches, dropouts and resets.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8) toggle_wait(8);
            else if (r < 14) toggle_wait(16);
            else if (r == 14) toggle_wait(12);
            else if (r == 15) toggle_wait(13);
            else if (r < 18) toggle_wait($urandom_range(1, 30));
            else if (r == 18) toggle_wait($urandom_range(40, 60));
            else begin
                rst = 1'b1;
                bus.fsk_in = 1'($urandom_range(0, 1));
                @(negedge clk);
                rst = 1'b0;
            end
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
